// File: rtl/mmio_uart_pkg.sv
// mmio_uart_pkg: shared state encoding, register offsets and STATUS bit positions for mmio_uart_tx
package mmio_uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  localparam int DATA_OFS = 0;
  localparam int STATUS_OFS = 1;
  localparam int ST_BUSY = 0;
  localparam int ST_FULL = 1;
  localparam int ST_EMPTY = 2;
  localparam int ST_OVF = 3;
  localparam int ST_PAR = 4;
  localparam int ST_CNT = 8;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: power-of-two FIFO, push accepted when full only if a pop happens on the same edge
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic do_push, do_pop;
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign do_pop = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout = mem[rd_ptr];
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr] <= din;
endmodule

// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped 8N1 UART transmitter with FIFO; MMIO_UART_TX_PARITY_EN adds an even-parity bit
import mmio_uart_pkg::*;
module mmio_uart_tx #(
  parameter logic [14:0] BASE_ADDR = 15'd24577,
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [14:0] a_addr,
  input  logic        a_wr,
  input  logic [15:0] a_din,
  output logic [15:0] a_dout,
  output logic        tx
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int AW = $clog2(FIFO_DEPTH);
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [2:0] bit_idx;
  logic [7:0] shreg, fifo_dout;
  logic [AW:0] count;
  logic [15:0] status;
  logic ovf, full, empty, is_data, is_status, push, pop, last;
  logic unused_din;
  assign unused_din = ^{a_din[15:8], a_din[6:4], a_din[2:0]};
  assign is_data = a_addr == BASE_ADDR + 15'(DATA_OFS);
  assign is_status = a_addr == BASE_ADDR + 15'(STATUS_OFS);
  assign push = a_wr && is_data;
  assign last = cnt == CW'(CLKS_PER_BIT - 1);
  assign pop = !empty && (state == IDLE || (state == STOP && last));
  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk), .reset(reset), .push(push), .pop(pop), .din(a_din[7:0]),
    .dout(fifo_dout), .full(full), .empty(empty), .count(count)
  );
  always_comb begin
    state_n = state;
    case (state)
      IDLE:   state_n = empty ? IDLE : START;
      START:  state_n = last ? DATA : START;
`ifdef MMIO_UART_TX_PARITY_EN
      DATA:   state_n = last && &bit_idx ? PARITY : DATA;
      PARITY: state_n = last ? STOP : PARITY;
`else
      DATA:   state_n = last && &bit_idx ? STOP : DATA;
`endif
      STOP:   state_n = !last ? STOP : empty ? IDLE : START;
      default: state_n = IDLE;
    endcase
  end
  always_comb
    tx = state == START ? 1'b0 : state == DATA ? shreg[bit_idx] : state == PARITY ? ^shreg : 1'b1;
  always_comb begin
    status = '0;
    status[ST_BUSY] = state != IDLE;
    status[ST_FULL] = full;
    status[ST_EMPTY] = empty;
    status[ST_OVF] = ovf;
`ifdef MMIO_UART_TX_PARITY_EN
    status[ST_PAR] = 1'b1;
`endif
    status[ST_CNT +: 4] = 4'(count);
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      cnt <= '0;
      bit_idx <= '0;
      shreg <= '0;
      ovf <= 1'b0;
      a_dout <= '0;
    end else begin
      state <= state_n;
      cnt <= (state_n != state || last || state == IDLE) ? '0 : cnt + 1'b1;
      if (state == DATA && last) bit_idx <= bit_idx + 3'd1;
      if (pop) shreg <= fifo_dout;
      if (push && full && !pop) ovf <= 1'b1;
      else if (a_wr && is_status && a_din[3]) ovf <= 1'b0;
      a_dout <= is_status ? status : '0;
    end
endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb_mmio_uart_tx: directed plus randomized bench against a frame-timer model of mmio_uart_tx (MMIO_UART_TX_PARITY_EN aware)
module tb_mmio_uart_tx;
  localparam int CPB = 4;
  localparam int DEPTH = 4;
  localparam logic [14:0] DAT = 15'd24577;
  localparam logic [14:0] STA = 15'd24578;
`ifdef MMIO_UART_TX_PARITY_EN
  localparam int NB = 11;
  localparam logic PAR = 1'b1;
`else
  localparam int NB = 10;
  localparam logic PAR = 1'b0;
`endif
  localparam int FL = CPB * NB;
  localparam logic [15:0] PBIT = PAR ? 16'h0010 : 16'h0000;
  localparam logic [15:0] IDLE_ST = 16'h0004 | PBIT;
  logic clk = 0, reset = 0, a_wr = 0, tx;
  logic [14:0] a_addr = '0;
  logic [15:0] a_din = '0, a_dout;
  int ntot = 0, npass = 0, nfail = 0;
  logic [7:0] q[$];
  int timer = 0;
  logic [7:0] cur = '0;
  logic m_ovf = 0;
  logic [15:0] m_dout = '0;
  mmio_uart_tx #(.BASE_ADDR(DAT), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .a_addr(a_addr), .a_wr(a_wr), .a_din(a_din), .a_dout(a_dout), .tx(tx)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    ntot++;
    assert (got === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s got %h exp %h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic logic m_tx();
    int p, b;
    if (timer == 0) return 1'b1;
    p = FL - timer;
    b = p / CPB;
    if (b == 0) return 1'b0;
    if (b <= 8) return cur[b-1];
    if (PAR && b == 9) return ^cur;
    return 1'b1;
  endfunction
  function automatic logic [15:0] m_status();
    logic [15:0] s;
    s = '0;
    s[0] = timer > 0;
    s[1] = q.size() == DEPTH;
    s[2] = q.size() == 0;
    s[3] = m_ovf;
    s[4] = PAR;
    s[11:8] = 4'(q.size());
    return s;
  endfunction
  task automatic model_edge(input logic wr, input logic [14:0] addr, input logic [15:0] din);
    int sz;
    logic pop;
    m_dout = addr == STA ? m_status() : 16'h0000;
    sz = q.size();
    pop = sz > 0 && timer <= 1;
    if (pop) begin
      cur = q.pop_front();
      timer = FL;
    end else if (timer > 0) timer--;
    if (wr && addr == DAT) begin
      if (sz < DEPTH || pop) q.push_back(din[7:0]);
      else m_ovf = 1'b1;
    end else if (wr && addr == STA && din[3]) m_ovf = 1'b0;
  endtask
  task automatic cyc(input logic wr, input logic [14:0] addr, input logic [15:0] din);
    a_wr = wr;
    a_addr = addr;
    a_din = din;
    @(posedge clk);
    model_edge(wr, addr, din);
    #1;
    chk("tx", {15'b0, tx}, {15'b0, m_tx()});
    chk("dout", a_dout, m_dout);
    a_wr = 1'b0;
  endtask
  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 15'd0, 16'h0000);
  endtask
  task automatic do_reset();
    reset = 1'b0;
    #1;
    q.delete();
    timer = 0;
    m_ovf = 1'b0;
    m_dout = '0;
    chk("rst_tx", {15'b0, tx}, 16'h0001);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_dout", a_dout, 16'h0000);
    reset = 1'b1;
  endtask
  initial begin
    logic [14:0] odd_addr [4];
    odd_addr[0] = DAT - 15'd1;
    odd_addr[1] = DAT + 15'd2;
    odd_addr[2] = 15'd0;
    odd_addr[3] = 15'd16384;
    repeat (3) @(posedge clk);
    #1;
    chk("por_tx", {15'b0, tx}, 16'h0001);
    chk("por_dout", a_dout, 16'h0000);
    reset = 1'b1;
    cyc(1'b0, STA, 16'h0000);
    chk("reset_status", a_dout, IDLE_ST);
    cyc(1'b1, DAT, 16'hAB55);
    chk("pre_start_tx", {15'b0, tx}, 16'h0001);
    cyc(1'b0, 15'd0, 16'h0000);
    chk("start_bit", {15'b0, tx}, 16'h0000);
    idle(FL);
    cyc(1'b0, STA, 16'h0000);
    chk("single_done_status", a_dout, IDLE_ST);
    for (int i = 1; i <= 6; i++) cyc(1'b1, DAT, 16'(i));
    cyc(1'b0, STA, 16'h0000);
    chk("ovf_status", a_dout, 16'h040B | PBIT);
    cyc(1'b1, STA, 16'h0008);
    cyc(1'b0, STA, 16'h0000);
    chk("ovf_clear_status", a_dout, 16'h0403 | PBIT);
    idle(5 * FL + 5);
    cyc(1'b0, STA, 16'h0000);
    chk("drained_status", a_dout, IDLE_ST);
    cyc(1'b1, DAT, 16'h0000);
    cyc(1'b1, DAT, 16'h0011);
    cyc(1'b1, DAT, 16'h0022);
    idle(11);
    chk("midframe_tx", {15'b0, tx}, 16'h0000);
    do_reset();
    cyc(1'b0, STA, 16'h0000);
    chk("post_reset_status", a_dout, IDLE_ST);
    idle(3 * FL);
    for (int i = 0; i < 400; i++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 10) cyc(1'b1, DAT, 16'($urandom));
      else if (r < 16) cyc(1'b0, STA, 16'h0000);
      else if (r < 19) cyc(1'b1, STA, 16'($urandom));
      else if (r < 22) cyc(1'b1, odd_addr[$urandom_range(0, 3)], 16'($urandom));
      else if (r < 24) cyc(1'b0, DAT, 16'h0000);
      else cyc(1'b0, 15'd0, 16'h0000);
    end
    idle(6 * FL);
    cyc(1'b1, STA, 16'h0008);
    cyc(1'b0, STA, 16'h0000);
    chk("final_status", a_dout, IDLE_ST);
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule

// File: doc/mmio_uart_tx.md
# mmio_uart_tx

Memory-mapped UART transmitter that answers the Hack CPU's data-memory bus (`addressM`/`writeM`/`outM`/`inM`) alongside the data RAM. The CPU writes bytes to a DATA register. The block queues them in a small FIFO and serialises them on `tx` as 8N1 frames. A STATUS register lets firmware poll for space before writing.

## Interface
Parameters:
- `BASE_ADDR`, 15'd24577: word address of DATA; STATUS is at `BASE_ADDR+1`.
- `CLKS_PER_BIT`, 16: clock cycles per serial bit, ≥2.
- `FIFO_DEPTH`, 4: FIFO entries, power of two, 2..8.

Ports:
- `clk`  in  1  system clock; every register updates on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `a_addr`  in  15  CPU data address (`addressM`).
- `a_wr`  in  1  CPU write strobe (`writeM`).
- `a_din`  in  16  CPU write data (`outM`).
- `a_dout`  out  16  registered read data; 0 when the address is unmapped; ORed into `inM` at system level.
- `tx`  out  1  serial line, idles high.

## Operation
- DATA write (`a_wr` and `a_addr==BASE_ADDR`): `a_din[7:0]` is pushed; `a_din[15:8]` is ignored.
- DATA write when FIFO is full: the byte is dropped and sticky `ovf` is set. Exception: a pop on the same edge makes the push accepted.
- STATUS write: `a_din[3]=1` clears `ovf`; all other bits are ignored.
- STATUS read word:
  - bit0 `busy` (FSM not IDLE)
  - bit1 `full`
  - bit2 `empty`
  - bit3 `ovf`
  - bits[11:8] FIFO count
  - all other bits 0
- DATA read returns 0.
- FSM states: IDLE, START, DATA, STOP (plus PARITY when the parity feature is compiled in).
  - IDLE→START when FIFO is not empty: pop into the 8-bit shift register; `tx`=0.
  - START→DATA after `CLKS_PER_BIT` cycles; bits are sent LSB first; 3-bit bit index.
  - DATA→STOP after the 8th bit; `tx`=1 for `CLKS_PER_BIT` cycles.
  - On STOP's last cycle: go to START if FIFO is not empty, popping that same edge (no idle gap between frames); otherwise go to IDLE.
- Baud counter runs 0..`CLKS_PER_BIT-1` and is cleared on every state change.
- FIFO pointers are log2(`FIFO_DEPTH`) bits, wrap modulo depth; count is log2+1 bits.

## Timing
- Reset values: `tx`=1, `a_dout`=0, FSM=IDLE, FIFO empty, `ovf`=0, counters 0.
- Reset asserted mid-frame aborts at once: `tx`=1 and FIFO contents are discarded.
- Read latency is 1 cycle: `a_dout` reflects the address presented before edge k, taken from register state sampled at edge k.
- A write at edge k is visible in STATUS read data from edge k+1.
- First-byte latency: push at edge k; pop and `tx` falls at edge k+1.
- Frame length is 10·`CLKS_PER_BIT` cycles (11· with parity).
- `busy` falls at the edge ending STOP when the FIFO is empty.

## Configuration
- `MMIO_UART_TX_PARITY_EN` defined:
  - PARITY state between DATA and STOP.
  - Sends even parity (XOR of the 8 data bits) for `CLKS_PER_BIT` cycles.
  - STATUS bit4 reads 1.
- Undefined: no PARITY state; STATUS bit4 reads 0.

## Structure
- Package `mmio_uart_pkg` holds:
  - state enum
  - register offsets (`DATA_OFS`=0, `STATUS_OFS`=1)
  - STATUS bit index constants
- Sub-module `sync_fifo` (params WIDTH, DEPTH): ports `push`, `pop`, `din`, `dout`, `full`, `empty`, `count`; same clock and reset as the top.
- Top holds address decode, read mux, `ovf` flag and TX FSM.

## Test plan
All scenarios use `CLKS_PER_BIT`=4 and `FIFO_DEPTH`=4.
- **Reset state:** after reset deassertion, read STATUS → `a_dout`=16'h0004; `tx`=1.
- **Single byte:** write 16'h0055 to DATA at edge k → `tx` falls at k+1. Then 4-cycle bits 1,0,1,0,1,0,1,0, then 1; `busy`=0 at k+41.
- **Fill and overflow:** six DATA writes on consecutive edges (bytes 01..06).
  - Byte 01 goes straight to the shifter; bytes 02–05 fill the FIFO; byte 06 is dropped.
  - STATUS then reads 16'h040B.
  - `tx` then carries 01,02,03,04,05 back-to-back with no idle gap.
- **Clear overflow:** write 16'h0008 to STATUS → `ovf`=0 in the next read; the FIFO is untouched.
- **Reset mid-frame:** assert `reset` 13 cycles into a frame with 2 bytes queued → `tx`=1 immediately; after release STATUS=16'h0004 and no further frames are sent.
- **Parity (macro defined):** write 16'h0007 → data bits 1,1,1,0,0,0,0,0, parity 1, stop; frame lasts 44 cycles.
